// File: rtl/aha_reset_pkg.sv
// aha_reset_pkg: sequencer FSM encoding and a parameter-legality check shared by the reset sequencer.
`define AHA_RESET_PARAM_CHECK(ss, n, st, g) \
    if (!((ss) >= 2 && (n) >= 1 && (st) >= 1 && (g) >= 1)) begin : g_param_check \
        $error("aha_reset_sequencer: illegal parameters"); \
    end
package aha_reset_pkg;
    typedef enum logic [1:0] {ST_ASSERT = 2'd0, ST_RELEASE = 2'd1, ST_RUN = 2'd2} state_t;
endpackage

// File: rtl/aha_reset_sequencer_if.sv
// aha_reset_sequencer_if: software reset request plus sequenced active-low resets and done flag.
interface aha_reset_sequencer_if #(parameter int NCH = 4);
    logic           sw_rst_req;
    logic [NCH-1:0] rstn;
    logic           done;
    modport master (output sw_rst_req, input rstn, done);
    modport slave  (input sw_rst_req, output rstn, done);
endinterface

// File: rtl/aha_sync_chain.sv
// aha_sync_chain: generic N-deep reset synchroniser, asserts asynchronously, releases on clock.
module aha_sync_chain #(parameter int STAGES = 2) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_sync <= '0;
        else r_sync <= {r_sync[STAGES-2:0], 1'b1};
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/aha_reset_sequencer.sv
// aha_reset_sequencer: asserts NCH domain resets asynchronously and releases them in order,
// STRETCH cycles after synchronised release and GAP cycles apart; software request restarts.
module aha_reset_sequencer
    import aha_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NCH         = 4,
    parameter int STRETCH     = 16,
    parameter int GAP         = 4
) (
    input logic i_clk,
    input logic i_rst,
    aha_reset_sequencer_if.slave bus
);
    localparam int CW = $clog2(STRETCH + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam int HW = $clog2(NCH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STRETCH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    localparam logic [HW-1:0] CH_LAST  = HW'(NCH - 1);

    `AHA_RESET_PARAM_CHECK(SYNC_STAGES, NCH, STRETCH, GAP)

    state_t         r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [GW-1:0]  r_gap, w_gap;
    logic [HW-1:0]  r_ch, w_ch;
    logic [NCH-1:0] r_rstn, w_rstn;
    logic           r_done, w_done;
    logic           w_rst_sync;

    aha_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (.i_clk, .i_rst, .o_q(w_rst_sync));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_ch    <= '0;
            r_rstn  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_gap   <= w_gap;
            r_ch    <= w_ch;
            r_rstn  <= w_rstn;
            r_done  <= w_done;
        end
    end

    // Releases shift a 1 in from bit 0, so ordering stays monotonic by construction.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_gap   = r_gap;
        w_ch    = r_ch;
        w_rstn  = r_rstn;
        w_done  = r_done;
        if (bus.sw_rst_req) begin
            w_state = ST_ASSERT;
            w_cnt   = '0;
            w_gap   = '0;
            w_ch    = '0;
            w_rstn  = '0;
            w_done  = 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT: if (w_rst_sync) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt   = '0;
                        w_rstn  = NCH'(1);
                        w_ch    = HW'(1);
                        w_done  = (NCH == 1);
                        w_state = (NCH == 1) ? ST_RUN : ST_RELEASE;
                    end else w_cnt = r_cnt + 1'b1;
                end
                ST_RELEASE: if (r_gap == GAP_LAST) begin
                    w_gap  = '0;
                    w_rstn = NCH'({r_rstn, 1'b1});
                    w_ch   = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
                    w_done = (r_ch == CH_LAST);
                    w_state = (r_ch == CH_LAST) ? ST_RUN : ST_RELEASE;
                end else w_gap = r_gap + 1'b1;
                ST_RUN: ;
                default: w_state = ST_ASSERT;
            endcase
        end
    end

    assign bus.rstn = r_rstn;
    assign bus.done = r_done;
endmodule

// File: tb/tb_aha_reset_sequencer.sv
// tb_aha_reset_sequencer: directed and random stimulus checked against an edge-count release model.
module tb_aha_reset_sequencer;
    localparam int SS = 2, NCH = 4, ST = 16, GAP = 4;
    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;
    int n_chk = 0, n_pass = 0;
    int edge_n = 0, f_edge = 0, e_sw = -1000;

    always #5 clk = ~clk;

    aha_reset_sequencer_if #(.NCH(NCH)) bus ();
    aha_reset_sequencer_if #(.NCH(1))   bus1 ();

    aha_reset_sequencer #(.SYNC_STAGES(SS), .NCH(NCH), .STRETCH(ST), .GAP(GAP)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus));
    aha_reset_sequencer #(.SYNC_STAGES(2), .NCH(1), .STRETCH(1), .GAP(1)) dut1 (
        .i_clk(clk), .i_rst(rst1), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, edge_n);
    endtask

    // Channel k is free once the edge count reaches start + STRETCH + k*GAP, where start is the
    // later of the synchronised release edge and the last sampled software request.
    function automatic logic [NCH-1:0] model_rstn(input int e);
        int start;
        logic [NCH-1:0] r;
        start = (e_sw > f_edge + SS) ? e_sw : f_edge + SS;
        r = '0;
        for (int k = 0; k < NCH; k++) r[k] = (e >= start + ST + k * GAP);
        return rst ? '0 : r;
    endfunction

    task automatic step(input logic nrst, input logic nsw);
        logic [NCH-1:0] exp, inc;
        @(posedge clk);
        edge_n++;
        if (bus.sw_rst_req && !rst) e_sw = edge_n;
        #1;
        exp = model_rstn(edge_n);
        inc = bus.rstn + 1'b1;
        check("rstn", 32'(bus.rstn), 32'(exp));
        check("done", 32'(bus.done), 32'(&exp));
        check("mono", 32'(bus.rstn & inc), 0);
        check("done_eq_and", 32'(bus.done), 32'(&bus.rstn));
        if (rst && !nrst) f_edge = edge_n;
        rst = nrst;
        bus.sw_rst_req = nsw;
        #1;
        if (nrst) begin
            check("async_rstn", 32'(bus.rstn), 0);
            check("async_done", 32'(bus.done), 0);
        end
    endtask

    task automatic follow(input string tag, input int lat, input bit sync_on, input bit n1_on);
        for (int m = 1; m <= lat + 14; m++) begin
            step(1'b0, 1'b0);
            if (sync_on) check({tag, "_sync"}, 32'(dut.u_sync.o_q), 1);
            if (n1_on && m == 2) check("n1_early", 32'(bus1.rstn), 0);
            if (n1_on && m == 3) begin
                check("n1_rstn", 32'(bus1.rstn), 1);
                check("n1_done", 32'(bus1.done), 1);
            end
            if (m == lat - 1) check({tag, "_pre"}, 32'(bus.rstn), 0);
            if (m == lat) check({tag, "_ch0"}, 32'(bus.rstn), 4'h1);
            if (m == lat + GAP) check({tag, "_ch1"}, 32'(bus.rstn), 4'h3);
            if (m == lat + 2 * GAP) check({tag, "_ch2"}, 32'(bus.rstn), 4'h7);
            if (m == lat + 3 * GAP - 1) begin
                check({tag, "_ch3_pre"}, 32'(bus.rstn), 4'h7);
                check({tag, "_done_pre"}, 32'(bus.done), 0);
            end
            if (m == lat + 3 * GAP) begin
                check({tag, "_ch3"}, 32'(bus.rstn), 4'hf);
                check({tag, "_done"}, 32'(bus.done), 1);
            end
        end
    endtask

    initial begin
        bus.sw_rst_req  = 1'b0;
        bus1.sw_rst_req = 1'b0;
        repeat (5) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        rst1 = 1'b0;
        follow("pwr_on", SS + ST, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int m = 1; m <= 23; m++) step(1'b0, 1'b0);
        check("pulse_pre", 32'(bus.rstn), 4'h3);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        follow("restart", SS + ST, 1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        check("sw_clr", 32'(bus.rstn), 0);
        follow("sw_pulse", ST, 1'b1, 1'b0);
        repeat (10) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        follow("sw_hold", ST, 1'b1, 1'b0);
        for (int i = 0; i < 10000; i++) begin
            logic nr, ns;
            nr = rst ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 299) == 0);
            ns = bus.sw_rst_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 59) == 0);
            step(nr, ns);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
